// File: rtl/regfile_wb_arb.sv
// regfile_wb_arb: round-robin arbiter in front of the single register-file write port.
// NREQ writeback sources compete through valid/ready handshakes. The winner's address and
// data are registered onto ar3o/r3o/we3o one cycle after the grant.
// A saturating counter records the cycles in which more than one source was waiting.
// Optional feature macro: REGFILE_WB_ARB_FWD_EN. When it is defined, the block adds
// write-to-read forwarding outputs for two decode read ports.
module regfile_wb_arb #(
  parameter int NREQ  = 2,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [5*NREQ-1:0]    req_addr,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 wb_hold,
  output logic                 we3o,
  output logic [4:0]           ar3o,
  output logic [31:0]          r3o,
`ifdef REGFILE_WB_ARB_FWD_EN
  input  logic [4:0]           ar1i,
  input  logic [4:0]           ar2i,
  output logic                 fwd1_hit,
  output logic                 fwd2_hit,
  output logic [31:0]          fwd1_data,
  output logic [31:0]          fwd2_data,
`endif
  output logic [CNT_W-1:0]     conf_cnt
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  // True when at least two bits of the request vector are set.
  function automatic logic multi_hot(input logic [NREQ-1:0] v);
    return (v & (v - NREQ'(1))) != '0;
  endfunction

  logic [PTR_W-1:0]  rr_ptr_r;
  logic [PTR_W:0]    sum_s;
  logic [PTR_W-1:0]  cand_s;
  logic [PTR_W-1:0]  gidx_s;
  logic [NREQ-1:0]   grant_s;
  logic              found_s;
  logic              xfer_s;
  logic [4:0]        win_addr_s;
  logic [31:0]       win_data_s;
  logic              we3o_r;
  logic [4:0]        ar3o_r;
  logic [31:0]       r3o_r;
  logic [CNT_W-1:0]  conf_cnt_r;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping modulo NREQ.
  always_comb begin
    grant_s = '0;
    gidx_s  = '0;
    found_s = 1'b0;
    sum_s   = '0;
    cand_s  = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum_s = {1'b0, rr_ptr_r} + (PTR_W+1)'(i);
      if (sum_s >= (PTR_W+1)'(NREQ)) begin
        sum_s = sum_s - (PTR_W+1)'(NREQ);
      end else begin
        sum_s = sum_s;
      end
      cand_s = sum_s[PTR_W-1:0];
      if (!found_s && req_valid[cand_s]) begin
        found_s         = 1'b1;
        gidx_s          = cand_s;
        grant_s[cand_s] = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Select the winner's address and data; grant_s is one-hot or zero.
  always_comb begin
    win_addr_s = 5'd0;
    win_data_s = 32'd0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_s[k]) begin
        win_addr_s = req_addr[5*k +: 5];
        win_data_s = req_data[32*k +: 32];
      end else begin
        win_addr_s = win_addr_s;
      end
    end
  end

  // Grants are suppressed while the port is held or while reset is applied.
  assign xfer_s    = found_s & ~wb_hold & rst;
  assign req_ready = xfer_s ? grant_s : '0;

  // Advance the priority pointer past the requester that just transferred.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_r <= '0;
    end else if (xfer_s) begin
      if (gidx_s == PTR_W'(NREQ-1)) begin
        rr_ptr_r <= '0;
      end else begin
        rr_ptr_r <= gidx_s + PTR_W'(1);
      end
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Register the write port; an x0 write is accepted but never enabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we3o_r <= 1'b0;
      ar3o_r <= 5'd0;
      r3o_r  <= 32'd0;
    end else if (xfer_s) begin
      we3o_r <= (win_addr_s != 5'd0);
      ar3o_r <= win_addr_s;
      r3o_r  <= win_data_s;
    end else begin
      we3o_r <= 1'b0;
      ar3o_r <= ar3o_r;
      r3o_r  <= r3o_r;
    end
  end

  // Count cycles with two or more requesters waiting, saturating at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conf_cnt_r <= '0;
    end else if (multi_hot(req_valid) && !wb_hold && (conf_cnt_r != {CNT_W{1'b1}})) begin
      conf_cnt_r <= conf_cnt_r + CNT_W'(1);
    end else begin
      conf_cnt_r <= conf_cnt_r;
    end
  end

  assign we3o     = we3o_r;
  assign ar3o     = ar3o_r;
  assign r3o      = r3o_r;
  assign conf_cnt = conf_cnt_r;

`ifdef REGFILE_WB_ARB_FWD_EN
  // Bypass the write being committed this cycle to the decode read ports.
  assign fwd1_hit  = we3o_r & (ar3o_r == ar1i) & (ar1i != 5'd0);
  assign fwd2_hit  = we3o_r & (ar3o_r == ar2i) & (ar2i != 5'd0);
  assign fwd1_data = fwd1_hit ? r3o_r : 32'd0;
  assign fwd2_data = fwd2_hit ? r3o_r : 32'd0;
`endif

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Testbench for regfile_wb_arb (NREQ=2, CNT_W=4). Uses a vector table plus directed
// sequences for saturation, asynchronous mid-stream reset and optional forwarding.
module tb_regfile_wb_arb;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [9:0]  req_addr;
  logic [63:0] req_data;
  logic [1:0]  req_ready;
  logic        wb_hold;
  logic        we3o;
  logic [4:0]  ar3o;
  logic [31:0] r3o;
  logic [3:0]  conf_cnt;
`ifdef REGFILE_WB_ARB_FWD_EN
  logic [4:0]  ar1i;
  logic [4:0]  ar2i;
  logic        fwd1_hit;
  logic        fwd2_hit;
  logic [31:0] fwd1_data;
  logic [31:0] fwd2_data;
`endif

  int total;
  int bad;

  regfile_wb_arb #(.NREQ(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .wb_hold(wb_hold),
    .we3o(we3o), .ar3o(ar3o), .r3o(r3o),
`ifdef REGFILE_WB_ARB_FWD_EN
    .ar1i(ar1i), .ar2i(ar2i), .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
    .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
`endif
    .conf_cnt(conf_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  v;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        hold;
    logic [1:0]  rdy;
    logic        we;
    logic [4:0]  ar;
    logic [31:0] r;
    logic [3:0]  cnt;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mk(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                              input logic [4:0] a1, input logic [31:0] d1, input logic hold,
                              input logic [1:0] rdy, input logic we, input logic [4:0] ar,
                              input logic [31:0] r, input logic [3:0] cnt);
    vec_t t;
    t.v = v; t.a0 = a0; t.d0 = d0; t.a1 = a1; t.d1 = d1; t.hold = hold;
    t.rdy = rdy; t.we = we; t.ar = ar; t.r = r; t.cnt = cnt;
    return t;
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s (step %0d): got %h expected %h", nm, row, got, exp);
    end
  endtask

  // A request left waiting at one sample must be unchanged at the next.
  logic [1:0]  pend_q;
  logic [9:0]  addr_q;
  logic [63:0] data_q;
  initial pend_q = 2'b00;
  // Requesters must hold valid, address and data stable until granted.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (pend_q[k] && rst) begin
        chk("hold_rule", k, {req_valid[k], req_addr[5*k +: 5], req_data[32*k +: 32] == data_q[32*k +: 32]},
            {1'b1, addr_q[5*k +: 5], 1'b1});
      end
    end
    pend_q <= rst ? (req_valid & ~req_ready) : 2'b00;
    addr_q <= req_addr;
    data_q <= req_data;
  end

  initial begin
    //              v      a0     d0            a1     d1            hold  rdy    we    ar     r             cnt
    tbl[0]  = mk(2'b01, 5'd5,  32'h11,        5'd0,  32'h0,        1'b0, 2'b01, 1'b0, 5'd0,  32'h0,        4'd0);
    tbl[1]  = mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,        1'b0, 2'b00, 1'b1, 5'd5,  32'h11,       4'd0);
    tbl[2]  = mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,        1'b0, 2'b00, 1'b0, 5'd5,  32'h11,       4'd0);
    tbl[3]  = mk(2'b11, 5'd1,  32'hA1,        5'd11, 32'hB1,       1'b0, 2'b10, 1'b0, 5'd5,  32'h11,       4'd0);
    tbl[4]  = mk(2'b11, 5'd1,  32'hA1,        5'd12, 32'hB2,       1'b0, 2'b01, 1'b1, 5'd11, 32'hB1,       4'd1);
    tbl[5]  = mk(2'b11, 5'd2,  32'hA2,        5'd12, 32'hB2,       1'b0, 2'b10, 1'b1, 5'd1,  32'hA1,       4'd2);
    tbl[6]  = mk(2'b11, 5'd2,  32'hA2,        5'd13, 32'hB3,       1'b0, 2'b01, 1'b1, 5'd12, 32'hB2,       4'd3);
    tbl[7]  = mk(2'b11, 5'd3,  32'hA3,        5'd13, 32'hB3,       1'b0, 2'b10, 1'b1, 5'd2,  32'hA2,       4'd4);
    tbl[8]  = mk(2'b11, 5'd3,  32'hA3,        5'd14, 32'hB4,       1'b0, 2'b01, 1'b1, 5'd13, 32'hB3,       4'd5);
    tbl[9]  = mk(2'b11, 5'd4,  32'hA4,        5'd14, 32'hB4,       1'b0, 2'b10, 1'b1, 5'd3,  32'hA3,       4'd6);
    tbl[10] = mk(2'b01, 5'd4,  32'hA4,        5'd0,  32'h0,        1'b0, 2'b01, 1'b1, 5'd14, 32'hB4,       4'd7);
    tbl[11] = mk(2'b10, 5'd0,  32'h0,         5'd0,  32'hDEADBEEF, 1'b0, 2'b10, 1'b1, 5'd4,  32'hA4,       4'd7);
    tbl[12] = mk(2'b11, 5'd6,  32'h66,        5'd7,  32'h77,       1'b1, 2'b00, 1'b0, 5'd0,  32'hDEADBEEF, 4'd7);
    tbl[13] = mk(2'b11, 5'd6,  32'h66,        5'd7,  32'h77,       1'b1, 2'b00, 1'b0, 5'd0,  32'hDEADBEEF, 4'd7);
    tbl[14] = mk(2'b11, 5'd6,  32'h66,        5'd7,  32'h77,       1'b1, 2'b00, 1'b0, 5'd0,  32'hDEADBEEF, 4'd7);
    tbl[15] = mk(2'b11, 5'd6,  32'h66,        5'd7,  32'h77,       1'b0, 2'b01, 1'b0, 5'd0,  32'hDEADBEEF, 4'd7);
    tbl[16] = mk(2'b10, 5'd0,  32'h0,         5'd7,  32'h77,       1'b0, 2'b10, 1'b1, 5'd6,  32'h66,       4'd8);
    tbl[17] = mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,        1'b0, 2'b00, 1'b1, 5'd7,  32'h77,       4'd8);
    tbl[18] = mk(2'b01, 5'd8,  32'h88,        5'd0,  32'h0,        1'b0, 2'b01, 1'b0, 5'd7,  32'h77,       4'd8);
    tbl[19] = mk(2'b01, 5'd9,  32'h99,        5'd0,  32'h0,        1'b0, 2'b01, 1'b1, 5'd8,  32'h88,       4'd8);
    tbl[20] = mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,        1'b0, 2'b00, 1'b1, 5'd9,  32'h99,       4'd8);

    total = 0;
    bad   = 0;
    clk   = 1'b0;
    rst   = 1'b0;
    wb_hold  = 1'b0;
    req_addr = 10'd0;
    req_data = 64'd0;
    req_valid = 2'($urandom_range(1, 3));
`ifdef REGFILE_WB_ARB_FWD_EN
    ar1i = 5'd0;
    ar2i = 5'd0;
`endif

    // Reset held with requests present: nothing granted, nothing written.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_we3o", -1, 32'(we3o), 32'd0);
    chk("reset_ready", -1, 32'(req_ready), 32'd0);
    chk("reset_cnt", -1, 32'(conf_cnt), 32'd0);
    chk("reset_ar3o", -1, 32'(ar3o), 32'd0);
    chk("reset_r3o", -1, r3o, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // One row per cycle: drive, check before the edge, then take the edge.
    for (int i = 0; i < 21; i++) begin
      req_valid = tbl[i].v;
      req_addr  = {tbl[i].a1, tbl[i].a0};
      req_data  = {tbl[i].d1, tbl[i].d0};
      wb_hold   = tbl[i].hold;
      @(negedge clk);
      chk("ready", i, 32'(req_ready), 32'(tbl[i].rdy));
      chk("we3o", i, 32'(we3o), 32'(tbl[i].we));
      chk("ar3o", i, 32'(ar3o), 32'(tbl[i].ar));
      chk("r3o", i, r3o, tbl[i].r);
      chk("conf_cnt", i, 32'(conf_cnt), 32'(tbl[i].cnt));
      @(posedge clk);
      #1;
    end

`ifdef REGFILE_WB_ARB_FWD_EN
    // Forwarding: the committing write to x7 is visible on read port 1 only.
    req_valid = 2'b01;
    req_addr  = {5'd0, 5'd7};
    req_data  = {32'd0, 32'h55};
    ar1i = 5'd7;
    ar2i = 5'd0;
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    chk("fwd_we3o", 100, 32'(we3o), 32'd1);
    chk("fwd1_hit", 100, 32'(fwd1_hit), 32'd1);
    chk("fwd1_data", 100, fwd1_data, 32'h55);
    chk("fwd2_hit", 100, 32'(fwd2_hit), 32'd0);
    chk("fwd2_data", 100, fwd2_data, 32'd0);
    @(posedge clk);
    #1;
`endif

    // Sustained contention drives the 4-bit counter into saturation (8 + 20 > 15).
    req_valid = 2'b11;
    req_addr  = {5'd4, 5'd3};
    req_data  = {32'h44, 32'h33};
    repeat (20) @(posedge clk);
    #1;
    chk("sat_cnt", 200, 32'(conf_cnt), 32'd15);
    @(posedge clk);
    #1;
    chk("sat_hold", 201, 32'(conf_cnt), 32'd15);
    chk("sat_we3o", 201, 32'(we3o), 32'd1);

    // Asynchronous reset mid-cycle drops the in-flight write immediately.
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_we3o", 300, 32'(we3o), 32'd0);
    chk("mid_rst_cnt", 300, 32'(conf_cnt), 32'd0);
    chk("mid_rst_ready", 300, 32'(req_ready), 32'd0);
    chk("mid_rst_ar3o", 300, 32'(ar3o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 301, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("post_rst_we3o", 302, 32'(we3o), 32'd1);
    chk("post_rst_ar3o", 302, 32'(ar3o), 32'd3);
    chk("post_rst_r3o", 302, r3o, 32'h33);
    chk("post_rst_cnt", 302, 32'(conf_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
